clk_div_monitor: RTL

Measures a divided clock by sampling it as data on the fast system clock, so the measured signal is a data input, not a clock. Pulses on each rising and falling edge and reports period and high time in system-clock cycles. Flags lock once the period has matched the expected divisor for a run of consecutive periods. Sits downstream of the clock divider as its self-check and feeds edge pulses to logic that must act once per divided period without using the divided clock as a clock.

---
 rtl/clkmon_pkg.sv | 17 +
 rtl/edge_sync.sv | 37 +++
 rtl/clk_div_monitor.sv | 121 ++++++++++++
 3 files changed

// File: rtl/clkmon_pkg.sv
// Shared state encoding and default parameters for the divided-clock monitor.
package clkmon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } clkmon_state_e;

  localparam int N_EXP_DEF    = 3;
  localparam int CNT_W_DEF    = 8;
  localparam int LOCK_CNT_DEF = 4;

  // Width of the consecutive-good-period counter.
  localparam int GOOD_W = 3;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus history flop for a sampled strobe; gives the
// synchronized level, combinational edge detects and registered edge pulses.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise_det,
  output logic fall_det,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic s1, s2, s3;

  // NOTE: non-blocking assignments so each stage captures the previous stage's old value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      s1         <= din;
      s2         <= s1;
      s3         <= s2;
      rise_pulse <= rise_det;
      fall_pulse <= fall_det;
    end
  end

  assign level    = s2;
  assign rise_det = s2 & ~s3;
  assign fall_det = ~s2 & s3;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock sampled as data on clk,
// and asserts lock after LOCK_CNT consecutive periods equal to N_EXP.
module clk_div_monitor
  import clkmon_pkg::*;
#(
  parameter int N_EXP    = N_EXP_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  EXP_PERIOD = CNT_W'(N_EXP);
  localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(LOCK_CNT - 1);

  clkmon_state_e     state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  cnt_inc, period_d, high_time_d;
  logic              period_valid_d, err_d;
  logic              level, rise_det, fall_det, timeout, match;

  edge_sync u_edge_sync (
    .clk        (clk),
    .reset      (reset),
    .din        (clk_in),
    .level      (level),
    .rise_det   (rise_det),
    .fall_det   (fall_det),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  // The rise cycle itself is not yet in cnt, hence the +1 for the period.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign match   = (cnt_inc == EXP_PERIOD);
  assign timeout = (cnt_q == CNT_MAX);
  assign locked  = (state_q == LOCKED);

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    state_d        = state_q;
    good_d         = good_q;
    cnt_d          = cnt_q;
    hcnt_d         = hcnt_q;
    period_d       = period;
    high_time_d    = high_time;
    period_valid_d = 1'b0;
    err_d          = 1'b0;

    if (state_q == MEASURE || state_q == LOCKED) begin
      cnt_d  = timeout ? cnt_q : cnt_inc;
      hcnt_d = (level && hcnt_q != CNT_MAX) ? hcnt_q + CNT_W'(1) : hcnt_q;
      // hcnt is cleared on the rise cycle, so it is one short of the high time.
      if (fall_det) high_time_d = hcnt_q + CNT_W'(1);

      if (rise_det) begin
        cnt_d          = '0;
        hcnt_d         = '0;
        period_valid_d = 1'b1;
        period_d       = cnt_inc;
        if (!match) begin
          err_d   = 1'b1;
          good_d  = '0;
          state_d = MEASURE;
        end else if (state_q == MEASURE) begin
          good_d = good_q + GOOD_W'(1);
          if (good_q == GOOD_LAST) state_d = LOCKED;
        end
      end else if (timeout) begin
        // Counter pinned at its maximum: treat clk_in as stuck.
        err_d   = 1'b1;
        good_d  = '0;
        cnt_d   = '0;
        hcnt_d  = '0;
        state_d = IDLE;
      end
    end else begin
      cnt_d   = '0;
      hcnt_d  = '0;
      state_d = IDLE;
      if (rise_det) begin
        good_d  = '0;
        state_d = MEASURE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      good_q       <= '0;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      period       <= period_d;
      high_time    <= high_time_d;
      period_valid <= period_valid_d;
      err          <= err_d;
    end
  end

endmodule
